// File: rtl/md_pad_pkg.sv
// Shared types and constants for the Mega Drive pad scanner: FSM encodings,
// output-word bit positions, pad pin indices and the scan shadow record.
package md_pad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_GAP    = 2'd0;
  localparam state_t S_SCAN   = 2'd1;
  localparam state_t S_COMMIT = 2'd2;

  // Bit positions in the published 16-bit button word.
  localparam int unsigned BTN_R     = 0;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_D     = 2;
  localparam int unsigned BTN_U     = 3;
  localparam int unsigned BTN_B     = 4;
  localparam int unsigned BTN_C     = 5;
  localparam int unsigned BTN_A     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_MODE  = 8;
  localparam int unsigned BTN_X     = 9;
  localparam int unsigned BTN_Y     = 10;
  localparam int unsigned BTN_Z     = 11;

  // Indices into the 6-pin pad bus.
  localparam int unsigned PIN_UP    = 0;
  localparam int unsigned PIN_DOWN  = 1;
  localparam int unsigned PIN_LEFT  = 2;
  localparam int unsigned PIN_RIGHT = 3;
  localparam int unsigned PIN_B     = 4;
  localparam int unsigned PIN_C     = 5;

  typedef struct packed {
    logic [15:0] word;
    logic        present;
    logic        six;
  } shadow_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/md_phase_decode.sv
// Combinational per-phase pin decode: folds one phase's sampled (active-high)
// pins into the scan shadow word, presence flag and 6-button flag.
module md_phase_decode
  import md_pad_pkg::*;
(
  input  logic [2:0] phase_i,
  input  logic [5:0] pins_i,
  input  shadow_t    shadow_i,
  output shadow_t    shadow_o
);

  always_comb begin
    shadow_o = shadow_i;
    case (phase_i)
      3'd0: begin
        shadow_o.word[BTN_U] = pins_i[PIN_UP];
        shadow_o.word[BTN_D] = pins_i[PIN_DOWN];
        shadow_o.word[BTN_L] = pins_i[PIN_LEFT];
        shadow_o.word[BTN_R] = pins_i[PIN_RIGHT];
        shadow_o.word[BTN_B] = pins_i[PIN_B];
        shadow_o.word[BTN_C] = pins_i[PIN_C];
      end
      3'd1: begin
        // A real pad pulls Left and Right low while select is low.
        shadow_o.present          = pins_i[PIN_LEFT] & pins_i[PIN_RIGHT];
        shadow_o.word[BTN_A]      = pins_i[PIN_B];
        shadow_o.word[BTN_START]  = pins_i[PIN_C];
      end
      3'd5: begin
        shadow_o.six = pins_i[PIN_UP] & pins_i[PIN_DOWN] & pins_i[PIN_LEFT] & pins_i[PIN_RIGHT];
      end
      3'd6: begin
        shadow_o.word[BTN_Z]    = shadow_i.six & pins_i[PIN_UP];
        shadow_o.word[BTN_Y]    = shadow_i.six & pins_i[PIN_DOWN];
        shadow_o.word[BTN_X]    = shadow_i.six & pins_i[PIN_LEFT];
        shadow_o.word[BTN_MODE] = shadow_i.six & pins_i[PIN_RIGHT];
      end
      default: ;
    endcase
    shadow_o.word[15:12] = 4'h0;
  end

endmodule

// File: rtl/snac_md_pad_scanner.sv
// Alternately scans two Mega Drive pads on the shared DB9/SNAC port and
// publishes their button words, committing each pad's word atomically.
module snac_md_pad_scanner
  import md_pad_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 240,
  parameter int unsigned GAP_CYCLES  = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_present,
  output logic [1:0]  pad_six
);

  localparam int unsigned CntW = cnt_width(GAP_CYCLES, STEP_CYCLES);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] StepLast = CntW'(STEP_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      phase_q, phase_d;
  logic            pad_q, pad_d;
  logic            mdsel_q, mdsel_d;
  logic [5:0]      sync1_q, sync2_q;
  shadow_t         shadow_q, shadow_d, shadow_dec;
  logic [15:0]     joy1_q, joy1_d, joy2_q, joy2_d;
  logic [1:0]      present_q, present_d, six_q, six_d;
  logic [15:0]     commit_word;
  logic            commit_six;

  md_phase_decode u_decode (
    .phase_i  (phase_q),
    .pins_i   (~sync2_q),
    .shadow_i (shadow_q),
    .shadow_o (shadow_dec)
  );

  assign commit_word = shadow_q.present ? shadow_q.word : 16'h0000;
  assign commit_six  = shadow_q.present & shadow_q.six;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    phase_d   = phase_q;
    pad_d     = pad_q;
    shadow_d  = shadow_q;
    joy1_d    = joy1_q;
    joy2_d    = joy2_q;
    present_d = present_q;
    six_d     = six_q;
    case (state_q)
      S_GAP: begin
        shadow_d = '0;
        if (cnt_q == GapLast) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          phase_d = 3'd0;
        end
      end
      S_SCAN: begin
        if (cnt_q == StepLast) begin
          cnt_d    = '0;
          shadow_d = shadow_dec;
          if (phase_q == 3'd7) begin
            state_d = S_COMMIT;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_GAP;
        cnt_d   = '0;
        pad_d   = ~pad_q;
        if (pad_q) begin
          joy2_d       = commit_word;
          present_d[1] = shadow_q.present;
          six_d[1]     = commit_six;
        end else begin
          joy1_d       = commit_word;
          present_d[0] = shadow_q.present;
          six_d[0]     = commit_six;
        end
      end
      default: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
    endcase
    // Select follows the next state so the pin sees it in the same cycle as the FSM.
    mdsel_d = (state_d == S_SCAN) ? ~phase_d[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_GAP;
      cnt_q     <= '0;
      phase_q   <= 3'd0;
      pad_q     <= 1'b0;
      mdsel_q   <= 1'b1;
      sync1_q   <= 6'h3F;
      sync2_q   <= 6'h3F;
      shadow_q  <= '0;
      joy1_q    <= 16'h0000;
      joy2_q    <= 16'h0000;
      present_q <= 2'b00;
      six_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pad_q     <= pad_d;
      mdsel_q   <= mdsel_d;
      sync1_q   <= joy_in;
      sync2_q   <= sync1_q;
      shadow_q  <= shadow_d;
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      present_q <= present_d;
      six_q     <= six_d;
    end
  end

  assign joy_mdsel   = mdsel_q;
  assign joy_split   = pad_q;
  assign joystick1   = joy1_q;
  assign joystick2   = joy2_q;
  assign pad_present = present_q;
  assign pad_six     = six_q;

endmodule

// File: tb/tb_snac_md_pad_scanner.sv
// Bench for snac_md_pad_scanner: behavioural MD pads on both ports, a
// frame-timing reference model, and per-cycle output comparison.
module tb_snac_md_pad_scanner;

  localparam int unsigned STEP  = 4;
  localparam int unsigned GAP   = 16;
  localparam int unsigned FRAME = GAP + 8 * STEP + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_mdsel, joy_split;
  logic [15:0] joystick1, joystick2;
  logic [1:0]  pad_present, pad_six;

  snac_md_pad_scanner #(
    .STEP_CYCLES (STEP),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .joy_in      (joy_in),
    .joy_mdsel   (joy_mdsel),
    .joy_split   (joy_split),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .pad_present (pad_present),
    .pad_six     (pad_six)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Pad types: 0 none, 1 three-button, 2 six-button. Buttons in output-word layout.
  logic [1:0]  ptype0 = 2'd0, ptype1 = 2'd0;
  logic [11:0] btn0 = 12'h000, btn1 = 12'h000;

  // Behavioural pad: counts select falling edges, forgets after 12 idle cycles.
  int   pcnt = 0;
  int   pidle = 0;
  logic psel_prev = 1'b1;

  function automatic logic [5:0] pad_pins(input logic [1:0] t, input logic [11:0] b,
                                          input logic sel, input int c);
    logic [5:0] p;
    if (t == 2'd0) return 6'h3F;
    if (sel) begin
      if (t == 2'd2 && c == 3) p = {b[5], b[4], b[8], b[9], b[10], b[11]};
      else                     p = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (t == 2'd2 && c == 3) p = {b[7], b[6], 4'hF};
      else                     p = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~p;
  endfunction

  assign joy_in = joy_split ? pad_pins(ptype1, btn1, joy_mdsel, pcnt)
                            : pad_pins(ptype0, btn0, joy_mdsel, pcnt);

  always @(negedge clk) begin
    psel_prev <= joy_mdsel;
    if (joy_mdsel !== psel_prev) begin
      pidle <= 0;
      if (psel_prev === 1'b1 && joy_mdsel === 1'b0) pcnt <= pcnt + 1;
    end else begin
      if (pidle < 1000) pidle <= pidle + 1;
      if (pidle + 1 >= 12) pcnt <= 0;
    end
  end

  // Reference model: time since reset decides frame, pad and sample points.
  int unsigned kk = 0;
  logic        checking = 1'b0;
  logic [1:0]  s_type;
  logic [11:0] s_b0, s_b1, s_b6;
  logic [15:0] ej1 = 16'h0, ej2 = 16'h0;
  logic [1:0]  epres = 2'b00, esix = 2'b00;

  function automatic logic pad_of(input int unsigned k);
    return ((k / FRAME) % 2) == 1;
  endfunction

  function automatic logic [11:0] btn_of(input int unsigned k);
    return pad_of(k) ? btn1 : btn0;
  endfunction

  function automatic logic [1:0] type_of(input int unsigned k);
    return pad_of(k) ? ptype1 : ptype0;
  endfunction

  function automatic logic [15:0] exp_word(input logic [1:0] t, input logic [11:0] b0,
                                           input logic [11:0] b1, input logic [11:0] b6);
    logic [15:0] w;
    if (t == 2'd0) return 16'h0000;
    w = {8'h00, b1[7:6], b0[5:0]};
    if (t == 2'd2) w[11:8] = b6[11:8];
    return w;
  endfunction

  function automatic logic exp_mdsel(input int unsigned k);
    int unsigned r;
    r = k % FRAME;
    if (r < GAP) return 1'b1;
    if (r < GAP + 8 * STEP) return (((r - GAP) / STEP) % 2) == 0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      kk       <= 0;
      ej1      <= 16'h0;
      ej2      <= 16'h0;
      epres    <= 2'b00;
      esix     <= 2'b00;
      checking <= 1'b1;
    end else begin
      kk <= kk + 1;
      // Pin state one cycle into each sampled phase is what the scanner captures.
      case (kk % FRAME)
        GAP + 1:            begin s_type <= type_of(kk); s_b0 <= btn_of(kk); end
        GAP + STEP + 1:     s_b1 <= btn_of(kk);
        GAP + 6 * STEP + 1: s_b6 <= btn_of(kk);
        FRAME - 1: begin
          if (pad_of(kk)) begin
            ej2      <= exp_word(s_type, s_b0, s_b1, s_b6);
            epres[1] <= (s_type != 2'd0);
            esix[1]  <= (s_type == 2'd2);
          end else begin
            ej1      <= exp_word(s_type, s_b0, s_b1, s_b6);
            epres[0] <= (s_type != 2'd0);
            esix[0]  <= (s_type == 2'd2);
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t kk=%0d)", name, act, exp, $time, kk);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("joystick1", {16'h0, joystick1}, {16'h0, ej1});
      check("joystick2", {16'h0, joystick2}, {16'h0, ej2});
      check("pad_present", {30'h0, pad_present}, {30'h0, epres});
      check("pad_six", {30'h0, pad_six}, {30'h0, esix});
      check("joy_mdsel", {31'h0, joy_mdsel}, {31'h0, exp_mdsel(kk)});
      check("joy_split", {31'h0, joy_split}, {31'h0, pad_of(kk)});
    end
  end

  task automatic wait_mod(input int unsigned t, input int unsigned m);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((kk % m) != t && n < 4 * m);
    if ((kk % m) != t) begin
      tests++;
      fails++;
      $display("FAIL wait_mod: got kk%%%0d=%0d, expected %0d", m, kk % m, t);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int toggles, splits, n;
    logic pm, ps;

    repeat (3) @(negedge clk);
    check("rst_joystick1", {16'h0, joystick1}, 32'h0);
    check("rst_joystick2", {16'h0, joystick2}, 32'h0);
    check("rst_present", {30'h0, pad_present}, 32'h0);
    check("rst_six", {30'h0, pad_six}, 32'h0);
    check("rst_mdsel", {31'h0, joy_mdsel}, 32'h1);
    check("rst_split", {31'h0, joy_split}, 32'h0);
    reset = 1'b0;

    // No pads for three frames.
    toggles = 0;
    splits  = 0;
    pm = joy_mdsel;
    ps = joy_split;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (joy_mdsel != pm) toggles++;
      if (joy_split != ps) splits++;
      pm = joy_mdsel;
      ps = joy_split;
    end
    check("nopad_mdsel_toggles", toggles, 32'd24);
    check("nopad_split_changes", splits, 32'd3);
    check("nopad_joystick1", {16'h0, joystick1}, 32'h0);
    check("nopad_present", {30'h0, pad_present}, 32'h0);

    // 3-button pad on port 0 (Up+A+Start), 6-button on port 1 (Right+C+X+Mode).
    wait_mod(5, 2 * FRAME);
    ptype0 = 2'd1;
    btn0   = 12'h0C8;
    ptype1 = 2'd2;
    btn1   = 12'h321;
    wait_mod(FRAME, 2 * FRAME);
    check("p0_joystick1", {16'h0, joystick1}, 32'h00C8);
    check("p0_present0", {31'h0, pad_present[0]}, 32'h1);
    check("p0_six0", {31'h0, pad_six[0]}, 32'h0);
    check("p0_joystick2_idle", {16'h0, joystick2}, 32'h0);
    wait_mod(0, 2 * FRAME);
    check("p1_joystick2", {16'h0, joystick2}, 32'h0321);
    check("p1_six1", {31'h0, pad_six[1]}, 32'h1);
    check("p1_joystick1_held", {16'h0, joystick1}, 32'h00C8);
    check("p1_present", {30'h0, pad_present}, 32'h3);

    // Release Up after the phase-0 sample of a pad-0 scan.
    wait_mod(GAP + 3 * STEP + 2, 2 * FRAME);
    btn0 = 12'h0C0;
    wait_mod(FRAME, 2 * FRAME);
    check("rel_old_word", {16'h0, joystick1}, 32'h00C8);
    wait_mod(FRAME, 2 * FRAME);
    check("rel_new_word", {16'h0, joystick1}, 32'h00C0);

    // Random buttons and pad types, checked every cycle by the model.
    repeat (12 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, 11);
        if ($urandom_range(0, 1) == 0) btn0[n] = ~btn0[n];
        else                           btn1[n] = ~btn1[n];
      end
      if ((kk % FRAME) == 13 && $urandom_range(0, 2) == 0) begin
        ptype0 = 2'($urandom_range(0, 2));
        ptype1 = 2'($urandom_range(0, 2));
      end
    end

    // Reset pulse during phase 5.
    ptype0 = 2'd2;
    ptype1 = 2'd1;
    btn0   = 12'hFFF;
    btn1   = 12'h0FF;
    wait_mod(GAP + 5 * STEP + 1, FRAME);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_joystick1", {16'h0, joystick1}, 32'h0);
    check("midrst_joystick2", {16'h0, joystick2}, 32'h0);
    check("midrst_present", {30'h0, pad_present}, 32'h0);
    check("midrst_six", {30'h0, pad_six}, 32'h0);
    check("midrst_mdsel", {31'h0, joy_mdsel}, 32'h1);
    n = 0;
    while (joy_mdsel && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n < GAP + STEP || n >= 200) begin
      fails++;
      $display("FAIL midrst_first_fall: got %0d cycles, expected >= %0d and < 200", n, GAP + STEP);
    end
    wait_mod(FRAME + 1, 2 * FRAME);
    check("midrst_rescan_joystick1", {16'h0, joystick1}, 32'h0FFF);
    check("midrst_rescan_six0", {31'h0, pad_six[0]}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snac_md_pad_scanner.md
Name: snac_md_pad_scanner

Overview:
- Scans two Mega Drive 3- or 6-button pads wired to the DB9/SNAC user port.
- Drives the shared select line (joy_mdsel) and the port-split line (joy_split), and samples the 6 active-low data pins.
- Publishes two active-high 16-bit button words in the layout the game-input mapping consumes.
- Sits directly upstream of the top-level joystick muxing; its outputs feed the joy1/joy2 selection and the OSD menu direction input.

Parameters:
- STEP_CYCLES, 240, clk cycles per select phase (10 us at 24 MHz); sample taken on last cycle of phase.
- GAP_CYCLES, 48000, idle cycles with joy_mdsel=1 after each pad scan (2 ms, exceeds the 6-button pad counter timeout of ~1.5 ms).

Ports:
- clk  in  1  system clock (24 MHz)
- reset  in  1  synchronous, active-high reset
- joy_in  in  6  pad pins, active low: [0]Up [1]Down [2]Left [3]Right [4]B/A [5]C/Start
- joy_mdsel  out  1  pad select line, registered
- joy_split  out  1  port select, registered; 0 = pad 1 connected, 1 = pad 2 connected
- joystick1  out  16  pad 1 buttons, active high
- joystick2  out  16  pad 2 buttons, active high
- pad_present  out  2  [0] pad 1 detected, [1] pad 2 detected
- pad_six  out  2  6-button pad detected, per pad

Behaviour:
- Output word bits: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z [15:12]=0.
- Reset values: joy_mdsel=1, joy_split=0, joystick1=joystick2=0, pad_present=0, pad_six=0. FSM goes to S_GAP with pad index 0 and the counter cleared.
- FSM states:
  - S_GAP: joy_mdsel=1. After GAP_CYCLES cycles, go to S_SCAN with phase=0.
  - S_SCAN: 8 phases, each STEP_CYCLES long. joy_mdsel = ~phase[0], so phase 0 drives high and phases alternate H,L,H,L,H,L,H,L. On the last cycle of each phase, sample the inverted joy_in into a per-pad shadow register.
  - S_COMMIT: one cycle. Writes the shadow to joystick/pad_present/pad_six for the current pad, toggles the pad index and joy_split, then goes to S_GAP.
- joy_split changes only in S_COMMIT, so it is stable throughout every scan and gap.
- Per-phase sampling (joy_in already inverted, so 1 = pressed / driven low):
  - Phase 0: U, D, L, R, B, C.
  - Phase 1: U and D ignored. pad present = raw Left==0 && raw Right==0. A = bit4, Start = bit5.
  - Phase 5: six = raw U, D, L, R all 0.
  - Phase 6: if six, Z=U pin, Y=D pin, X=L pin, Mode=R pin.
  - Phases 2, 3, 4, 7 are not sampled.
- Pad not present: the committed word is 0 and six=0.
- 3-button pad: bits [11:8] are 0.
- Outputs change only in S_COMMIT. Each word is updated atomically; a pad's word never mixes data from two scans.
- Frame period per pad = 2*(GAP_CYCLES + 8*STEP_CYCLES + 1) cycles.
- Counter width = clog2(max(GAP_CYCLES, STEP_CYCLES)). It saturates nowhere; it reloads at each state or phase boundary.
- Reset asserted mid-scan: on the next edge, all outputs return to their reset values and the shadow is discarded. The scan always restarts from S_GAP, so the pad's internal counter times out before the next scan.
- joy_in is double-flop synchronized before sampling. The sample therefore reflects pin state 2 cycles before the last phase cycle; STEP_CYCLES ≥ 4 is required.

Decomposition:
- Shared package md_pad_pkg holds:
  - state enum {S_GAP, S_SCAN, S_COMMIT}
  - bit-position constants BTN_R..BTN_Z
  - pin index constants PIN_UP..PIN_C
- The pin-to-word mapping per phase is one natural sub-module: md_phase_decode. It is combinational: phase, synced pins and shadow in; next shadow, present and six out.
- FSM, counters and output registers stay in the top.

Test Plan:
- Test params STEP_CYCLES=4, GAP_CYCLES=16. Pad model is a behavioural MD pad with an internal phase counter and a 1.5 ms-equivalent (12-cycle) timeout.
- No pad (joy_in=6'h3F constant) for 3 frames -> joystick1=joystick2=0, pad_present=2'b00, joy_mdsel toggles 8 times per scan, joy_split alternates after each commit.
- 3-button pad on port 0 holding Up+A+Start -> after first commit, joystick1=16'h00C8, pad_present[0]=1, pad_six[0]=0.
- 6-button pad on port 1 holding Right+C+X+Mode -> joystick2=16'h0321, pad_six[1]=1. joystick1 is unchanged during port-1 commit.
- Button released mid-scan after phase 0 -> old word is held until commit, new word appears only at the next commit for that pad, with no partial update.
- Reset pulse during phase 5 -> next cycle all outputs 0 and joy_mdsel=1; the next joy_mdsel falling edge is no earlier than GAP_CYCLES+STEP_CYCLES cycles later.
